// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: a small circular FIFO between fetch and decode.
// Holds {pc, inst} packets, supports push and pop in the same cycle, and
// is cleared in one edge by a redirect flush. Flushed entries are added
// to a saturating drop counter. The head entry is masked to zero when the
// queue is empty.
module inst_fetch_queue #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_allowin,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_allowin,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam int SUM_W = ((CNT_W > CW) ? CNT_W : CW) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;
  logic [SUM_W-1:0]  drop_sum;
  logic              drop_sat;

  // Status flags, handshakes and the masked head entry.
  // NOTE: every output of a combinational block gets a value on every path
  // (here by a default first), otherwise synthesis infers a latch.
  always_comb begin
    full       = 1'b0;
    empty      = 1'b0;
    in_allowin = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    push       = 1'b0;
    pop        = 1'b0;
    drop_sum   = '0;
    drop_sat   = 1'b0;

    full       = (count == CW'(DEPTH));
    empty      = (count == '0);
    in_allowin = !full || out_allowin;
    out_valid  = !empty;
    if (out_valid) begin
      out_data = mem[rd_ptr];
    end
    // Flush wins over both handshakes; a full queue can still take a new
    // entry when the head leaves in the same cycle.
    push     = in_valid && in_allowin && !flush;
    pop      = out_valid && out_allowin && !flush;
    drop_sum = SUM_W'(drop_cnt) + SUM_W'(count);
    drop_sat = (drop_sum > SUM_W'(CNT_MAX));
  end

  // Entry storage: written at the write pointer on an accepted push.
  // NOTE: the storage array is deliberately left out of reset; its contents
  // are never visible because out_data is masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointers and occupancy: advance on handshakes, clear on flush.
  // NOTE: state registers use non-blocking assignments so all of them
  // update together from the values seen before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Flush statistics: add the discarded occupancy, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (flush) begin
      drop_cnt <= drop_sat ? CNT_MAX : drop_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: a queue-based reference model predicts
// occupancy, flags and head data every cycle; popped entries are compared
// against the scoreboard in arrival order. A second instance with a 2-bit
// drop counter shares the stimulus to exercise saturation.
module tb_inst_fetch_queue;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_allowin;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_allowin;
  logic [DATA_W-1:0] out_data;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;
  logic [15:0]       drop_cnt;

  logic              in_allowin_s;
  logic              out_valid_s;
  logic [DATA_W-1:0] out_data_s;
  logic [CW-1:0]     count_s;
  logic              full_s;
  logic              empty_s;
  logic [1:0]        drop_cnt_s;

  int unsigned n_compared = 0;
  int unsigned n_mismatched = 0;

  logic [DATA_W-1:0] sb [$];
  longint unsigned   exp_drop16;
  longint unsigned   exp_drop2;

  inst_fetch_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_allowin(in_allowin), .in_data(in_data),
    .out_valid(out_valid), .out_allowin(out_allowin), .out_data(out_data),
    .count(count), .full(full), .empty(empty), .drop_cnt(drop_cnt)
  );

  inst_fetch_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_allowin(in_allowin_s), .in_data(in_data),
    .out_valid(out_valid_s), .out_allowin(out_allowin), .out_data(out_data_s),
    .count(count_s), .full(full_s), .empty(empty_s), .drop_cnt(drop_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Checks the flags of the main instance against the model occupancy.
  task automatic check_status(input string tag);
    int unsigned n;
    n = sb.size();
    check({tag, ".count"}, 64'(count), 64'(n));
    check({tag, ".full"}, 64'(full), 64'(n == DEPTH));
    check({tag, ".empty"}, 64'(empty), 64'(n == 0));
    check({tag, ".out_valid"}, 64'(out_valid), 64'(n != 0));
    check({tag, ".in_allowin"}, 64'(in_allowin), 64'((n < DEPTH) || out_allowin));
    check({tag, ".drop16"}, 64'(drop_cnt), exp_drop16);
    check({tag, ".drop2"}, 64'(drop_cnt_s), exp_drop2);
    check({tag, ".count_s"}, 64'(count_s), 64'(n));
  endtask

  // One clock cycle: drive inputs, check at the falling edge, update model.
  // Entered and left at 1 time unit after a rising edge.
  task automatic cycle(input logic v, input logic [63:0] d, input logic oa, input logic fl);
    logic do_push;
    logic do_pop;
    int unsigned n;
    in_valid    = v;
    in_data     = d;
    out_allowin = oa;
    flush       = fl;
    @(negedge clk);
    check_status("cyc");
    n       = sb.size();
    do_push = v && ((n < DEPTH) || oa) && !fl;
    do_pop  = (n != 0) && oa && !fl;
    if (do_pop) begin
      check("pop_data", out_data, sb.pop_front());
    end else if (n == 0) begin
      check("idle_zero", out_data, 64'h0);
    end else begin
      check("head", out_data, sb[0]);
    end
    check("data_s", out_data_s, out_data);
    if (fl) begin
      exp_drop16 = exp_drop16 + n;
      if (exp_drop16 > 64'hFFFF) exp_drop16 = 64'hFFFF;
      exp_drop2 = exp_drop2 + n;
      if (exp_drop2 > 3) exp_drop2 = 3;
      sb.delete();
    end else if (do_push) begin
      sb.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".count"}, 64'(count), 64'h0);
    check({tag, ".empty"}, 64'(empty), 64'h1);
    check({tag, ".full"}, 64'(full), 64'h0);
    check({tag, ".out_valid"}, 64'(out_valid), 64'h0);
    check({tag, ".out_data"}, out_data, 64'h0);
    check({tag, ".in_allowin"}, 64'(in_allowin), 64'h1);
    check({tag, ".drop_cnt"}, 64'(drop_cnt), 64'h0);
    check({tag, ".drop_cnt_s"}, 64'(drop_cnt_s), 64'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_drop16  = 0;
    exp_drop2   = 0;
    rst         = 1'b1;
    flush       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    out_allowin = 1'b0;

    @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // First push right after reset, then an async reset with 2 entries held.
    cycle(1'b1, 64'hA1, 1'b0, 1'b0);
    cycle(1'b1, 64'hA2, 1'b0, 1'b0);
    check("two_held", 64'(count), 64'h2);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fill with the consumer stalled.
    cycle(1'b1, 64'h10, 1'b0, 1'b0);
    cycle(1'b1, 64'h20, 1'b0, 1'b0);
    cycle(1'b1, 64'h30, 1'b0, 1'b0);
    cycle(1'b1, 64'h40, 1'b0, 1'b0);
    check("fill.full", 64'(full), 64'h1);
    check("fill.count", 64'(count), 64'h4);
    check("fill.in_allowin", 64'(in_allowin), 64'h0);
    // Offer while full and stalled: must be refused.
    cycle(1'b1, 64'hDEAD, 1'b0, 1'b0);

    // Full queue with simultaneous push and pop.
    cycle(1'b1, 64'h50, 1'b1, 1'b0);
    check("fullpp.count", 64'(count), 64'h4);
    check("fullpp.head", out_data, 64'h20);

    // Drain.
    for (int i = 0; i < 4; i++) cycle(1'b0, 64'h0, 1'b1, 1'b0);
    check("drain.empty", 64'(empty), 64'h1);
    check("drain.out_data", out_data, 64'h0);
    // Pop request on empty queue: nothing leaves.
    cycle(1'b0, 64'h0, 1'b1, 1'b0);

    // Streaming across pointer wrap: occupancy stays at 1.
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b1, 64'(i), 1'b1, 1'b0);
      check("stream.count", 64'(count), 64'h1);
    end
    cycle(1'b0, 64'h0, 1'b1, 1'b0);

    // Flush with 3 queued and an entry offered in the same cycle.
    cycle(1'b1, 64'h61, 1'b0, 1'b0);
    cycle(1'b1, 64'h62, 1'b0, 1'b0);
    cycle(1'b1, 64'h63, 1'b0, 1'b0);
    cycle(1'b1, 64'h99, 1'b0, 1'b1);
    check("flush.count", 64'(count), 64'h0);
    check("flush.empty", 64'(empty), 64'h1);
    check("flush.drop", 64'(drop_cnt), 64'h3);
    cycle(1'b0, 64'h0, 1'b1, 1'b0);

    // Second flush of 3: the 2-bit counter saturates, the 16-bit one adds.
    cycle(1'b1, 64'h71, 1'b0, 1'b0);
    cycle(1'b1, 64'h72, 1'b0, 1'b0);
    cycle(1'b1, 64'h73, 1'b0, 1'b0);
    cycle(1'b0, 64'h0, 1'b0, 1'b1);
    check("sat.drop2", 64'(drop_cnt_s), 64'h3);
    check("sat.drop16", 64'(drop_cnt), 64'h6);

    // Random mix of pushes, pops and occasional flushes.
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 2) != 0), {32'h0, 32'($urandom)},
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 24) == 0));
    end
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 64'h0, 1'b1, 1'b0);
    check("final.empty", 64'(empty), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
